bin2bcd8_seq: RTL
=================

# bin2bcd8_seq

Multi-cycle sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It takes one WIDTH-bit binary operand per start request and returns NDIG packed BCD digits after WIDTH iteration cycles. It is the area-reduced, handshake-controlled counterpart to the combinational `bin2bcd8` and sits between a binary producer (counter, ALU result) and a digit display/driver stage. Outputs stay stable during a conversion and change only when a new result completes.

## Interface
Parameters:
- `WIDTH`, default 8: binary operand width; also the number of iteration cycles.
- `NDIG`, default 3: number of BCD output digits. The constraint 10^NDIG > 2^WIDTH−1 must hold; a violation is an elaboration error.

Ports:
- `clk`  in  1  sole clock; rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  conversion request; sampled on rising edge when `ready`=1.
- `bin`  in  WIDTH  operand; captured on the accepting edge only.
- `ready`  out  1  high when idle and able to accept `start`.
- `busy`  out  1  high while a conversion is in progress (equals ~`ready`).
- `done`  out  1  one-cycle pulse when a new result is loaded onto `bcd`.
- `bcd`  out  4·NDIG  result. Nibble 0 [3:0] is the units digit, nibble 1 the tens digit, nibble 2 the hundreds digit, and so on.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- **IDLE:** `ready`=1.
  - On an edge with `start`=1: load shift register ← `bin`, clear the working BCD register and the iteration counter, then go to SHIFT.
- **SHIFT:** one iteration per edge.
  - First, every working digit ≥5 gets +3 (4-bit add, no carry out of the nibble).
  - Then shift {working BCD, shift register} left by 1, and increment the counter.
  - On the edge that completes iteration WIDTH, load `bcd` ← final working BCD and go to DONE.
- **DONE:** `done`=1 for exactly this cycle. The next edge returns to IDLE unconditionally.
- `start` is ignored in SHIFT and DONE. There is no queuing, and `bin` changes in those states have no effect.
- `bcd` holds its last result indefinitely. It updates only on the SHIFT→DONE edge and never shows intermediate values.
- Counter width is clog2(WIDTH+1). It must not wrap before reaching WIDTH.
- Every output digit is always in 0..9. The maximum operand (255 for WIDTH=8) yields 2/5/5.

## Timing
- **Reset values:** state=IDLE, `ready`=1, `busy`=0, `done`=0, `bcd`=0. Shift register, working register and counter are all cleared.
- **Reset mid-operation:** the conversion is aborted immediately and asynchronously. `bcd` returns to 0, not to the previous result.
- Deassertion of `rst` is synchronous to `clk`. `start` on the first edge after deassertion is accepted.
- **Latency:** take the accepting edge as E0.
  - `busy` is high for cycles E0→E(WIDTH+1).
  - `bcd` is updated and `done` rises at edge E(WIDTH). For WIDTH=8 that is edge 8.
  - `done` falls at E(WIDTH+1), when `ready` returns high.
- **Throughput:** one conversion per WIDTH+2 cycles when `start` is held high continuously.
- If `start` is still high at E(WIDTH+1), that is the IDLE-entry edge and it is not sampled. It is accepted on the following edge, E(WIDTH+2).
- `ready`, `busy` and `done` are registered state decodes. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert `rst` with no clock running → `bcd`=12'h000, `ready`=1, `done`=0 immediately.
- **Boundary values:** convert `bin`=0, 9, 10, 99, 100, 255 (WIDTH=8) → `bcd` = 12'h000, 009, 010, 099, 100, 255 respectively.
  - `done` is high exactly one cycle, 8 edges after the accepting edge.
  - `bcd` is unchanged on every cycle before `done`.
- **Busy protection:** start a conversion of 200, then pulse `start` with `bin`=37 at E3 and again in the DONE cycle → result 12'h200, exactly one `done` pulse, and the 37 request is dropped.
- **Reset mid-conversion:** start 123, assert `rst` at E4 → outputs return to reset values, no `done` pulse. Then convert 45 → 12'h045.
- **Back-to-back with `start` held high:** operands 17 then 250 → results 12'h017 then 12'h250. The second accepting edge is 10 edges after the first.
- **Exhaustive:** sweep 0..255 → hundreds·100 + tens·10 + units equals `bin`, and each digit ≤9. Also run with WIDTH=10, NDIG=4: 1023 → 16'h1023.

Source files
------------

// File: rtl/bin2bcd8_seq.sv
// Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
// One WIDTH-bit operand per start handshake; the result appears WIDTH cycles after acceptance.
module bin2bcd8_seq #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * NDIG;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam bit FITS = pow10(NDIG) > ((64'd1 << WIDTH) - 64'd1);

    generate
        if (!FITS || WIDTH < 2) begin : g_bad_params
            $error("bin2bcd8_seq: NDIG digits cannot hold every WIDTH-bit operand");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sh;
    logic [BCD_W-1:0]   r_work;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_work_next;
    logic [WIDTH-1:0]   w_sh_next;
    logic               w_last;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_adj = r_work;
        for (int d = 0; d < NDIG; d++) begin
            if (r_work[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
        end
    end

    // One iteration: the MSB of the operand shifts into the units digit.
    assign w_work_next = {w_adj[BCD_W-2:0], r_sh[WIDTH-1]};
    assign w_sh_next   = {r_sh[WIDTH-2:0], 1'b0};
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sh    <= bin;
                        r_work  <= '0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_sh   <= w_sh_next;
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bcd   <= w_work_next;
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign bcd   = r_bcd;

endmodule
